cci_mpf_shim_rd_throttle: RTL

// - MPF shim between an AFU-side cci_mpf_if and an FIU-side cci_mpf_if.
// - Buffers channel 0 (read) requests in a FIFO.
// - Issues a buffered read only when the FIU is not almost full and the

---
 rtl/cci_mpf_shim_rd_throttle_if.sv | 90 +++++++++
 rtl/cci_mpf_shim_rd_throttle.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_rd_throttle_if.sv
// Shared types and the MPF interface bundle used by the read throttle shim.
// to_fiu faces the platform, to_afu faces user logic.
package cci_mpf_shim_rd_throttle_pkg;

  typedef logic [3:0] t_rsp_type;
  localparam t_rsp_type eRSP_RDLINE = 4'h0;
  localparam t_rsp_type eRSP_WRLINE = 4'h1;
  localparam t_rsp_type eRSP_UMSG   = 4'h4;
  localparam t_rsp_type eRSP_MMIO   = 4'h8;

  typedef struct packed {
    logic [1:0]  cl_len;
    logic [15:0] mdata;
    logic [41:0] addr;
  } t_req_base;

  typedef struct packed {
    t_req_base base;
  } t_c0_req_hdr;

  typedef struct packed {
    logic        valid;
    t_c0_req_hdr hdr;
    logic [3:0]  flags;
  } t_c0_tx;

  typedef struct packed {
    t_c0_req_hdr hdr;
    logic [3:0]  flags;
  } t_c0_ent;

  typedef struct packed {
    logic        valid;
    logic [41:0] addr;
    logic [15:0] mdata;
    logic [63:0] data;
  } t_c1_tx;

  typedef struct packed {
    logic        mmioRdValid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_c2_tx;

  typedef struct packed {
    t_rsp_type   resp_type;
    logic [15:0] mdata;
    logic [1:0]  cl_num;
  } t_rsp_hdr;

  typedef struct packed {
    logic        rspValid;
    logic        mmioRdValid;
    logic        mmioWrValid;
    t_rsp_hdr    hdr;
    logic [63:0] data;
  } t_c0_rx;

  typedef struct packed {
    logic     rspValid;
    t_rsp_hdr hdr;
  } t_c1_rx;

endpackage

interface cci_mpf_if;
  import cci_mpf_shim_rd_throttle_pkg::*;

  logic   reset;
  t_c0_tx c0Tx;
  t_c1_tx c1Tx;
  t_c2_tx c2Tx;
  logic   c0TxAlmFull;
  logic   c1TxAlmFull;
  t_c0_rx c0Rx;
  t_c1_rx c1Rx;

  modport to_fiu (
    output c0Tx, c1Tx, c2Tx,
    input  c0TxAlmFull, c1TxAlmFull,
    input  c0Rx, c1Rx
  );

  modport to_afu (
    output reset,
    output c0TxAlmFull, c1TxAlmFull,
    output c0Rx, c1Rx,
    input  c0Tx, c1Tx, c2Tx
  );
endinterface

// File: rtl/cci_mpf_shim_rd_throttle.sv
// Read throttle shim: queues c0 reads, issues them under a line credit.
// Optional stall counter built when CCI_MPF_RD_THROTTLE_STATS_EN is defined.
module cci_mpf_shim_rd_throttle
  import cci_mpf_shim_rd_throttle_pkg::*;
#(
  parameter int DEPTH                 = 32,
  parameter int ALM_FULL_SLACK        = 8,
  parameter int MAX_OUTSTANDING_LINES = 128
) (
  input  logic        clk,
  input  logic        reset,
  cci_mpf_if.to_fiu   fiu,
  cci_mpf_if.to_afu   afu,
  output logic [31:0] stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING_LINES + 1);
  localparam logic [AW:0] ALM_THR =
    (AW+1)'(DEPTH - ALM_FULL_SLACK);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [CW:0] MAX_L =
    (CW+1)'(MAX_OUTSTANDING_LINES);

  t_c0_ent       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [CW-1:0] outst;

  logic          empty;
  logic          full;
  logic          push_ok;
  logic          have;
  logic          issue;
  logic          wr;
  logic          pop;
  logic          rd_rsp;
  logic          credit_ok;
  t_c0_ent       in_ent;
  t_c0_ent       head;
  logic [2:0]    need;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] out_add;
  logic [CW-1:0] out_nxt;

  assign afu.reset       = reset;
  assign fiu.c1Tx        = afu.c1Tx;
  assign fiu.c2Tx        = afu.c2Tx;
  assign afu.c1TxAlmFull = fiu.c1TxAlmFull;
  assign afu.c0Rx        = fiu.c0Rx;
  assign afu.c1Rx        = fiu.c1Rx;

  assign empty   = (occ == '0);
  assign full    = (occ == FULL_N);
  assign push_ok = afu.c0Tx.valid && !full;
  assign in_ent  = '{hdr: afu.c0Tx.hdr,
                     flags: afu.c0Tx.flags};

  // An empty FIFO lets the incoming request bypass straight to issue.
  assign head = empty ? in_ent : mem[rd_ptr];
  assign have = !empty || push_ok;

  assign need       = {1'b0, head.hdr.base.cl_len} + 3'd1;
  assign credit_sum = {1'b0, outst} + (CW+1)'(need);
  assign credit_ok  = (credit_sum <= MAX_L);

  assign issue = have && !fiu.c0TxAlmFull && credit_ok;
  assign pop   = issue && !empty;
  assign wr    = push_ok && !(empty && issue);

  assign rd_rsp = fiu.c0Rx.rspValid &&
                  (fiu.c0Rx.hdr.resp_type == eRSP_RDLINE);

  // Responses with nothing in flight belong to pre-reset reads.
  assign out_add = issue ? outst + CW'(need) : outst;
  assign out_nxt = (rd_rsp && out_add != '0) ?
                   out_add - CW'(1) : out_add;

  // Request storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_ent;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

  // Registered issue toward the FIU and line credit tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fiu.c0Tx <= '0;
      outst    <= '0;
    end else begin
      fiu.c0Tx.valid <= issue;
      if (issue) begin
        fiu.c0Tx.hdr   <= head.hdr;
        fiu.c0Tx.flags <= head.flags;
      end
      outst <= out_nxt;
    end
  end

  // Almost-full tracks last cycle's occupancy; held high in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) afu.c0TxAlmFull <= 1'b1;
    else       afu.c0TxAlmFull <= (occ >= ALM_THR);
  end

`ifdef CCI_MPF_RD_THROTTLE_STATS_EN
  logic stall_en;
  assign stall_en = !empty && !fiu.c0TxAlmFull && !credit_ok;

  // Saturating count of cycles the head waits on credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_en && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

`ifndef SYNTHESIS
  // Pushing into a full FIFO is an AFU protocol error.
  always_ff @(posedge clk) begin
    if (!reset && afu.c0Tx.valid && full)
      $fatal(1, "c0 request pushed into full FIFO");
  end
`endif

endmodule
